// File: rtl/aes_pkg.sv
// aes_pkg: shared types, constant tables and GF(2^8) helpers for the AES-128
// decryption core.
//   aes_state_e      - controller state encoding
//   SBOX / INV_SBOX  - forward / inverse byte substitution tables
//   RCON[1..10]      - key-schedule round constants
//   xtime, sub_word, inv_shift_rows, inv_sub_bytes, inv_mix_column
// Byte order everywhere: byte 0 = [127:120]; column c = bytes 4c..4c+3.
package aes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_KEY_EXP     = 3'd1,
    ST_ADD_RK_INIT = 3'd2,
    ST_INV_SHIFT   = 3'd3,
    ST_INV_SUB     = 3'd4,
    ST_ADD_RK      = 3'd5,
    ST_INV_MIX     = 3'd6,
    ST_DONE        = 3'd7
  } aes_state_e;

  localparam logic [3:0] LAST_ROUND = 4'd10;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Multiply by x in GF(2^8), reduction polynomial 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  // Row r of the output takes column (c - r) mod 4 of the input.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int k = 0; k < 16; k++) begin
      o[127 - 8*k -: 8] = INV_SBOX[s[127 - 8*k -: 8]];
    end
    return o;
  endfunction

  // Coefficients 0e/0b/0d/09 are assembled from the x2, x4, x8 xtime chain.
  function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
    logic [7:0] a  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int k = 0; k < 4; k++) begin
      a[k]  = col[31 - 8*k -: 8];
      x2    = xtime(a[k]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[k] = x8 ^ a[k];
      mb[k] = x8 ^ x2 ^ a[k];
      md[k] = x8 ^ x4 ^ a[k];
      me[k] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

endpackage

// File: rtl/aes_key_expand_step.sv
// aes_key_expand_step: one AES-128 key-schedule step, purely combinational.
//   rk_prev_i [127:0] - previous round key rk[i-1]
//   rcon_i    [7:0]   - round constant Rcon[i]
//   rk_next_o [127:0] - next round key rk[i]
module aes_key_expand_step
  import aes_pkg::*;
(
  input  logic [127:0] rk_prev_i,
  input  logic [7:0]   rcon_i,
  output logic [127:0] rk_next_o
);

  logic [31:0] w0_s, w1_s, w2_s, w3_s;
  logic [31:0] temp_s;
  logic [31:0] n0_s, n1_s, n2_s, n3_s;

  // Word chain: SubWord(RotWord(w3)) ^ Rcon seeds the first word, the rest ripple.
  always_comb begin
    w0_s      = rk_prev_i[127:96];
    w1_s      = rk_prev_i[95:64];
    w2_s      = rk_prev_i[63:32];
    w3_s      = rk_prev_i[31:0];
    temp_s    = sub_word({w3_s[23:0], w3_s[31:24]}) ^ {rcon_i, 24'h000000};
    n0_s      = w0_s ^ temp_s;
    n1_s      = w1_s ^ n0_s;
    n2_s      = w2_s ^ n1_s;
    n3_s      = w3_s ^ n2_s;
    rk_next_o = {n0_s, n1_s, n2_s, n3_s};
  end

endmodule

// File: rtl/aes_decrypt_core.sv
// aes_decrypt_core: multi-cycle AES-128 decryption engine.
//   clk        - system clock
//   reset_n    - asynchronous active-low reset
//   msg_en     - ciphertext, latched when a request is accepted in IDLE
//   key        - cipher key, latched together with msg_en
//   io_ready   - request from the I/O block
//   msg_de     - registered plaintext, updated only on entry to DONE
//   aes_ready  - high in DONE until io_ready is seen low
// Flow: 10 key-expansion cycles, initial AddRoundKey, then per round
// InvShiftRows, InvSubBytes, AddRoundKey and (except the last) InvMixColumns
// one column per cycle. aes_ready rises 77 edges after the accepting edge.
module aes_decrypt_core
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic [127:0] msg_en,
  input  logic [127:0] key,
  input  logic         io_ready,
  output logic [127:0] msg_de,
  output logic         aes_ready
);

  aes_state_e   state_q;
  logic [127:0] st_q;
  logic [127:0] rk_q [0:10];
  logic [3:0]   i_q;
  logic [3:0]   r_q;
  logic [1:0]   c_q;
  logic [127:0] msg_de_q;
  logic         aes_ready_q;

  logic [127:0] key_prev_s;
  logic [127:0] key_next_s;
  logic [7:0]   rcon_s;
  logic [127:0] rk_round_s;
  logic [127:0] inv_shift_s;
  logic [127:0] inv_sub_s;
  logic [127:0] inv_mix_s;
  logic [31:0]  mix_col_s;
  logic [31:0]  mix_out_s;

  assign key_prev_s  = rk_q[i_q - 4'd1];
  assign rcon_s      = RCON[i_q];
  assign rk_round_s  = rk_q[r_q];
  assign inv_shift_s = inv_shift_rows(st_q);
  assign inv_sub_s   = inv_sub_bytes(st_q);

  aes_key_expand_step u_key_step (
    .rk_prev_i (key_prev_s),
    .rcon_i    (rcon_s),
    .rk_next_o (key_next_s)
  );

  // Select column c, mix it, and splice it back into an otherwise unchanged state.
  always_comb begin
    mix_col_s = 32'h0;
    inv_mix_s = st_q;
    case (c_q)
      2'd0:    mix_col_s = st_q[127:96];
      2'd1:    mix_col_s = st_q[95:64];
      2'd2:    mix_col_s = st_q[63:32];
      2'd3:    mix_col_s = st_q[31:0];
      default: mix_col_s = st_q[127:96];
    endcase
    mix_out_s = inv_mix_column(mix_col_s);
    case (c_q)
      2'd0:    inv_mix_s[127:96] = mix_out_s;
      2'd1:    inv_mix_s[95:64]  = mix_out_s;
      2'd2:    inv_mix_s[63:32]  = mix_out_s;
      2'd3:    inv_mix_s[31:0]   = mix_out_s;
      default: inv_mix_s         = st_q;
    endcase
  end

  // Controller, datapath registers and key-schedule register file.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      st_q        <= 128'h0;
      i_q         <= 4'd0;
      r_q         <= 4'd0;
      c_q         <= 2'd0;
      msg_de_q    <= 128'h0;
      aes_ready_q <= 1'b0;
      for (int k = 0; k < 11; k++) begin
        rk_q[k] <= 128'h0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          aes_ready_q <= 1'b0;
          if (io_ready) begin
            st_q    <= msg_en;
            rk_q[0] <= key;
            i_q     <= 4'd1;
            state_q <= ST_KEY_EXP;
          end
        end
        ST_KEY_EXP: begin
          rk_q[i_q] <= key_next_s;
          if (i_q == LAST_ROUND) begin
            state_q <= ST_ADD_RK_INIT;
          end else begin
            i_q <= i_q + 4'd1;
          end
        end
        ST_ADD_RK_INIT: begin
          st_q    <= st_q ^ rk_q[10];
          r_q     <= LAST_ROUND - 4'd1;
          state_q <= ST_INV_SHIFT;
        end
        ST_INV_SHIFT: begin
          st_q    <= inv_shift_s;
          state_q <= ST_INV_SUB;
        end
        ST_INV_SUB: begin
          st_q    <= inv_sub_s;
          state_q <= ST_ADD_RK;
        end
        ST_ADD_RK: begin
          st_q <= st_q ^ rk_round_s;
          if (r_q == 4'd0) begin
            // Last round skips InvMixColumns; publish the plaintext directly.
            msg_de_q    <= st_q ^ rk_round_s;
            aes_ready_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            c_q     <= 2'd0;
            state_q <= ST_INV_MIX;
          end
        end
        ST_INV_MIX: begin
          st_q <= inv_mix_s;
          if (c_q == 2'd3) begin
            r_q     <= r_q - 4'd1;
            state_q <= ST_INV_SHIFT;
          end else begin
            c_q <= c_q + 2'd1;
          end
        end
        ST_DONE: begin
          // Hold the result until the request is withdrawn; no restart on the same request.
          if (!io_ready) begin
            aes_ready_q <= 1'b0;
            state_q     <= ST_IDLE;
          end else begin
            aes_ready_q <= 1'b1;
          end
        end
        default: begin
          aes_ready_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign msg_de    = msg_de_q;
  assign aes_ready = aes_ready_q;

endmodule

// File: tb/tb_aes_decrypt_core.sv
// Self-checking bench for aes_decrypt_core: FIPS-197 vectors, handshake,
// operand-change, mid-operation reset and random vectors against a byte-level
// reference model whose S-boxes are derived from GF(2^8) inversion.
module tb_aes_decrypt_core;
  import aes_pkg::*;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic         clk;
  logic         reset_n;
  logic [127:0] msg_en;
  logic [127:0] key;
  logic         io_ready;
  logic [127:0] msg_de;
  logic         aes_ready;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] m_sbox     [256];
  logic [7:0] m_inv_sbox [256];

  aes_decrypt_core dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .msg_en    (msg_en),
    .key       (key),
    .io_ready  (io_ready),
    .msg_de    (msg_de),
    .aes_ready (aes_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl1(input logic [7:0] b);
    return {b[6:0], b[7]};
  endfunction

  // S-box = affine transform of the multiplicative inverse.
  task automatic build_sboxes();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      s = inv ^ rotl1(inv) ^ rotl1(rotl1(inv)) ^ rotl1(rotl1(rotl1(inv)))
          ^ rotl1(rotl1(rotl1(rotl1(inv)))) ^ 8'h63;
      m_sbox[x]    = s;
      m_inv_sbox[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] model_decrypt(input logic [127:0] ct, input logic [127:0] k);
    logic [31:0]  w   [44];
    logic [7:0]   st  [16];
    logic [7:0]   tmp [16];
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [31:0]  t;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {m_sbox[t[31:24]], m_sbox[t[23:16]], m_sbox[t[15:8]], m_sbox[t[7:0]]};
        t = t ^ {rc, 24'h000000};
        rc = gf_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int b = 0; b < 16; b++) st[b] = ct[127 - 8*b -: 8] ^ w[40 + b/4][31 - 8*(b%4) -: 8];
    for (int rnd = 9; rnd >= 0; rnd--) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) tmp[4*c + r] = st[4*((c - r + 4) % 4) + r];
      for (int b = 0; b < 16; b++) st[b] = m_inv_sbox[tmp[b]] ^ w[4*rnd + b/4][31 - 8*(b%4) -: 8];
      if (rnd > 0) begin
        for (int c = 0; c < 4; c++) begin
          a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
          st[4*c]   = gf_mul(a0,8'h0e) ^ gf_mul(a1,8'h0b) ^ gf_mul(a2,8'h0d) ^ gf_mul(a3,8'h09);
          st[4*c+1] = gf_mul(a0,8'h09) ^ gf_mul(a1,8'h0e) ^ gf_mul(a2,8'h0b) ^ gf_mul(a3,8'h0d);
          st[4*c+2] = gf_mul(a0,8'h0d) ^ gf_mul(a1,8'h09) ^ gf_mul(a2,8'h0e) ^ gf_mul(a3,8'h0b);
          st[4*c+3] = gf_mul(a0,8'h0b) ^ gf_mul(a1,8'h0d) ^ gf_mul(a2,8'h09) ^ gf_mul(a3,8'h0e);
        end
      end
    end
    res = 128'h0;
    for (int b = 0; b < 16; b++) res[127 - 8*b -: 8] = st[b];
    return res;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operands with io_ready high and let the accepting edge pass.
  task automatic start_op(input logic [127:0] ct, input logic [127:0] k);
    msg_en   = ct;
    key      = k;
    io_ready = 1'b1;
    step();
  endtask

  // Bounded wait for aes_ready; n counts edges after the accepting edge.
  task automatic wait_ready(input int n0, output int n);
    n = n0;
    while (aes_ready !== 1'b1 && n < 200) begin
      step();
      n++;
    end
  endtask

  initial begin
    int lat;
    int hold;
    logic [127:0] r_ct, r_key, r_exp;

    build_sboxes();
    reset_n  = 1'b0;
    io_ready = 1'b0;
    msg_en   = 128'h0;
    key      = 128'h0;
    repeat (3) step();
    chk("rst_ready", {127'h0, aes_ready}, 128'h0);
    chk("rst_msg", msg_de, 128'h0);
    chk("rst_state", {125'h0, dut.state_q}, {125'h0, ST_IDLE});
    reset_n = 1'b1;
    step();

    // C.1 with io_ready held, then hold and release.
    start_op(C1_CT, C1_KEY);
    wait_ready(0, lat);
    chk("c1_latency", 128'(lat), 128'd77);
    chk("c1_pt", msg_de, C1_PT);
    chk("c1_model", msg_de, model_decrypt(C1_CT, C1_KEY));
    for (int k = 0; k < 20; k++) begin
      step();
      chk("hold_ready", {127'h0, aes_ready}, 128'h1);
      chk("hold_msg", msg_de, C1_PT);
    end
    io_ready = 1'b0;
    step();
    chk("release_ready", {127'h0, aes_ready}, 128'h0);
    chk("release_msg", msg_de, C1_PT);
    chk("release_idle", {125'h0, dut.state_q}, {125'h0, ST_IDLE});

    // App. B with a one-cycle request pulse.
    start_op(B_CT, B_KEY);
    io_ready = 1'b0;
    repeat (10) step();
    chk("b_rk10", dut.rk_q[10], B_RK10);
    wait_ready(10, lat);
    chk("b_latency", 128'(lat), 128'd77);
    chk("b_pt", msg_de, B_PT);
    step();
    chk("pulse_one_cycle", {127'h0, aes_ready}, 128'h0);
    chk("pulse_msg_hold", msg_de, B_PT);

    // Operands change after the latch.
    start_op(C1_CT, C1_KEY);
    repeat (5) step();
    msg_en = {128{1'b1}};
    key    = {128{1'b1}};
    wait_ready(5, lat);
    chk("chg_latency", 128'(lat), 128'd77);
    chk("chg_pt", msg_de, C1_PT);
    io_ready = 1'b0;
    step();

    // Reset in the middle of an operation.
    start_op(C1_CT, C1_KEY);
    repeat (40) step();
    reset_n  = 1'b0;
    io_ready = 1'b0;
    #1;
    chk("midrst_ready", {127'h0, aes_ready}, 128'h0);
    chk("midrst_msg", msg_de, 128'h0);
    step();
    reset_n = 1'b1;
    step();
    chk("midrst_idle_ready", {127'h0, aes_ready}, 128'h0);
    start_op(C1_CT, C1_KEY);
    wait_ready(0, lat);
    chk("rerun_latency", 128'(lat), 128'd77);
    chk("rerun_pt", msg_de, C1_PT);
    io_ready = 1'b0;
    step();

    // Random vectors against the reference model.
    for (int v = 0; v < 6; v++) begin
      r_ct  = {$urandom(), $urandom(), $urandom(), $urandom()};
      r_key = {$urandom(), $urandom(), $urandom(), $urandom()};
      r_exp = model_decrypt(r_ct, r_key);
      hold  = int'($urandom_range(0, 3));
      start_op(r_ct, r_key);
      msg_en = {$urandom(), $urandom(), $urandom(), $urandom()};
      if (hold == 0) io_ready = 1'b0;
      wait_ready(0, lat);
      chk("rnd_latency", 128'(lat), 128'd77);
      chk("rnd_pt", msg_de, r_exp);
      repeat (hold) step();
      io_ready = 1'b0;
      step();
      chk("rnd_release", {127'h0, aes_ready}, 128'h0);
      chk("rnd_msg_hold", msg_de, r_exp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
